// File: rtl/gray_counter_mod.sv
// Up/down counter with programmable modulus, load, wrap/saturate mode and a
// registered Gray-code copy of the count that tracks qbin with zero latency.
module gray_counter_mod #(
    parameter int              WIDTH    = 4,
    parameter int unsigned     PVALUE   = 0,
    parameter longint unsigned MODULUS  = 0,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             cnt_en,
    input  logic             updown,
    input  logic             sclr,
    input  logic             sload,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] qbin,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped,
    output logic             sat
);

    localparam longint unsigned  C_M   = (MODULUS == 0) ? (64'd1 << WIDTH) : MODULUS;
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(C_M - 64'd1);
    localparam logic [WIDTH-1:0] C_PV  = WIDTH'(PVALUE);

    function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Load values outside the count range are pinned to the top of the range.
    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] d);
        if (64'(d) >= C_M)
            return C_MAX;
        return d;
    endfunction

    logic [WIDTH-1:0] r_qbin    = C_PV;
    logic [WIDTH-1:0] r_q       = gray(C_PV);
    logic             r_wrapped = 1'b0;
    logic             r_sat     = 1'b0;

    logic [WIDTH-1:0] w_qbin_nxt;
    logic             w_wrapped_nxt;
    logic             w_sat_nxt;
    logic             w_at_max;
    logic             w_at_min;

    assign w_at_max = (r_qbin == C_MAX);
    assign w_at_min = (r_qbin == '0);

    // Bounds are tested before stepping, so nothing beyond M-1 is ever stored.
    always_comb begin
        w_qbin_nxt    = r_qbin;
        w_wrapped_nxt = r_wrapped;
        w_sat_nxt     = r_sat;
        if (clk_en) begin
            w_wrapped_nxt = 1'b0;
            if (sclr) begin
                w_qbin_nxt = C_PV;
                w_sat_nxt  = 1'b0;
            end else if (sload) begin
                w_qbin_nxt = clamp(data);
                w_sat_nxt  = 1'b0;
            end else if (cnt_en) begin
                if (updown ? w_at_max : w_at_min) begin
                    if (SATURATE) begin
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_qbin_nxt    = updown ? '0 : C_MAX;
                        w_wrapped_nxt = 1'b1;
                        w_sat_nxt     = 1'b0;
                    end
                end else begin
                    w_qbin_nxt = updown ? (r_qbin + 1'b1) : (r_qbin - 1'b1);
                    w_sat_nxt  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_qbin    <= C_PV;
            r_q       <= gray(C_PV);
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_qbin    <= w_qbin_nxt;
            r_q       <= gray(w_qbin_nxt);
            r_wrapped <= w_wrapped_nxt;
            r_sat     <= w_sat_nxt;
        end
    end

    assign qbin    = r_qbin;
    assign q       = r_q;
    assign wrapped = r_wrapped;
    assign sat     = r_sat;
    assign tc      = updown ? w_at_max : w_at_min;

endmodule

// File: tb/tb_gray_counter_mod.sv
// Bench for gray_counter_mod: three configurations driven in lockstep and
// compared every cycle against an arithmetic model of the counting rules.
module tb_gray_counter_mod;

    logic       clock = 1'b0;
    logic       aclr = 1'b0;
    logic       clk_en = 1'b1;
    logic       cnt_en = 1'b0;
    logic       updown = 1'b1;
    logic       sclr = 1'b0;
    logic       sload = 1'b0;
    logic [3:0] data = 4'd0;

    logic [3:0] o_qbin [3];
    logic [3:0] o_q    [3];
    logic       o_tc   [3];
    logic       o_wr   [3];
    logic       o_sat  [3];

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Model configuration: modulus, preset value, saturate mode per instance.
    int M_ARR   [3] = '{16, 10, 10};
    int PV_ARR  [3] = '{0, 3, 0};
    bit SAT_ARR [3] = '{1'b0, 1'b0, 1'b1};

    int m_q [3];
    bit m_w [3];
    bit m_s [3];

    gray_counter_mod #(.WIDTH(4)) u0 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .cnt_en(cnt_en),
        .updown(updown), .sclr(sclr), .sload(sload), .data(data),
        .qbin(o_qbin[0]), .q(o_q[0]), .tc(o_tc[0]), .wrapped(o_wr[0]), .sat(o_sat[0]));

    gray_counter_mod #(.WIDTH(4), .PVALUE(3), .MODULUS(10), .SATURATE(1'b0)) u1 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .cnt_en(cnt_en),
        .updown(updown), .sclr(sclr), .sload(sload), .data(data),
        .qbin(o_qbin[1]), .q(o_q[1]), .tc(o_tc[1]), .wrapped(o_wr[1]), .sat(o_sat[1]));

    gray_counter_mod #(.WIDTH(4), .PVALUE(0), .MODULUS(10), .SATURATE(1'b1)) u2 (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .cnt_en(cnt_en),
        .updown(updown), .sclr(sclr), .sload(sload), .data(data),
        .qbin(o_qbin[2]), .q(o_q[2]), .tc(o_tc[2]), .wrapped(o_wr[2]), .sat(o_sat[2]));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_q[i] = PV_ARR[i];
            m_w[i] = 1'b0;
            m_s[i] = 1'b0;
        end
    endtask

    // One clock edge of the counting rules, using the inputs present at the edge.
    task automatic model_edge();
        int raw;
        for (int i = 0; i < 3; i++) begin
            if (clk_en) begin
                m_w[i] = 1'b0;
                if (sclr) begin
                    m_q[i] = PV_ARR[i];
                    m_s[i] = 1'b0;
                end else if (sload) begin
                    m_q[i] = (int'(data) >= M_ARR[i]) ? M_ARR[i] - 1 : int'(data);
                    m_s[i] = 1'b0;
                end else if (cnt_en) begin
                    raw = m_q[i] + (updown ? 1 : -1);
                    if (raw < 0 || raw >= M_ARR[i]) begin
                        if (SAT_ARR[i]) begin
                            m_s[i] = 1'b1;
                        end else begin
                            m_q[i] = (raw + M_ARR[i]) % M_ARR[i];
                            m_w[i] = 1'b1;
                            m_s[i] = 1'b0;
                        end
                    end else begin
                        m_q[i] = raw;
                        m_s[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        int exp_tc;
        for (int i = 0; i < 3; i++) begin
            exp_tc = updown ? int'(m_q[i] == M_ARR[i] - 1) : int'(m_q[i] == 0);
            chk($sformatf("%s.u%0d.qbin", tag, i), 32'(o_qbin[i]), 32'(m_q[i]));
            chk($sformatf("%s.u%0d.q", tag, i), 32'(o_q[i]), 32'(m_q[i] ^ (m_q[i] >> 1)));
            chk($sformatf("%s.u%0d.tc", tag, i), 32'(o_tc[i]), 32'(exp_tc));
            chk($sformatf("%s.u%0d.wrapped", tag, i), 32'(o_wr[i]), 32'(m_w[i]));
            chk($sformatf("%s.u%0d.sat", tag, i), 32'(o_sat[i]), 32'(m_s[i]));
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic aclr_pulse(input string tag);
        aclr = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        aclr = 1'b0;
    endtask

    initial begin
        logic [3:0] prev_q;
        model_reset();
        #2;
        check_all("time0");

        // Asynchronous clear with no clock edge.
        aclr_pulse("aclr_async");

        // Full-range up count: single-bit Gray steps, wrap pulse after 15->0.
        cnt_en = 1'b1;
        updown = 1'b1;
        for (int k = 0; k < 16; k++) begin
            prev_q = o_q[0];
            cyc($sformatf("up16_%0d", k));
            chk($sformatf("gray_1bit_%0d", k), 32'($countones(o_q[0] ^ prev_q)), 32'd1);
        end
        cyc("after_wrap");

        // From zero: up across modulus 10 (wrap and saturate), then down.
        sload = 1'b1;
        data  = 4'd0;
        cyc("load0");
        sload = 1'b0;
        for (int k = 0; k < 12; k++)
            cyc($sformatf("up12_%0d", k));
        updown = 1'b0;
        cyc("down_from_bound");
        sload = 1'b1;
        data  = 4'd0;
        cyc("load0_b");
        sload = 1'b0;
        cyc("down_wrap");
        cyc("down_after_wrap");

        // Load clamp, and sclr beating sload in the same cycle.
        sload = 1'b1;
        data  = 4'd13;
        cyc("load13");
        sclr = 1'b1;
        cyc("sclr_over_sload");
        sclr  = 1'b0;
        sload = 1'b0;

        // clk_en low freezes everything, flags included.
        updown = 1'b1;
        cyc("pre_freeze");
        clk_en = 1'b0;
        sclr   = 1'b1;
        sload  = 1'b1;
        data   = 4'd5;
        for (int k = 0; k < 5; k++)
            cyc($sformatf("freeze_%0d", k));

        // aclr overrides an in-flight load across an edge.
        clk_en = 1'b1;
        sclr   = 1'b0;
        aclr   = 1'b1;
        #1;
        model_reset();
        check_all("aclr_mid");
        @(posedge clock);
        #1;
        check_all("aclr_hold_edge");
        aclr = 1'b0;
        cyc("first_edge_after_aclr");
        sload = 1'b0;

        // Randomised traffic against the model.
        for (int k = 0; k < 300; k++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            cnt_en = ($urandom_range(0, 3) != 0);
            updown = 1'($urandom_range(0, 1));
            sclr   = ($urandom_range(0, 15) == 0);
            sload  = ($urandom_range(0, 9) == 0);
            data   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0)
                aclr_pulse($sformatf("rnd_aclr_%0d", k));
            cyc($sformatf("rnd_%0d", k));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
